sw_test_status_mon: RTL



---
 rtl/sw_test_status_mon.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/sw_test_status_mon.sv
// Multi-channel software test-status monitor: decodes status words snooped from per-core write
// streams into channel FSMs and a sticky done/pass/timeout verdict. Option: SW_TEST_STATUS_HEARTBEAT_EN.
module sw_test_status_mon #(
  parameter int unsigned NumChannels     = 2,
  parameter int unsigned AddrWidth       = 32,
  parameter int unsigned TimeoutCycles   = 0,
  parameter bit          FailFast        = 1'b1
`ifdef SW_TEST_STATUS_HEARTBEAT_EN
  ,
  parameter int unsigned HeartbeatCycles = 100000
`endif
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NumChannels-1:0]           wr_valid_i,
  input  logic [NumChannels*AddrWidth-1:0] wr_addr_i,
  input  logic [NumChannels*16-1:0]        wr_data_i,
  input  logic [NumChannels*AddrWidth-1:0] status_addr_i,
  output logic [NumChannels*3-1:0]         chan_state_o,
  output logic [NumChannels-1:0]           chan_done_o,
  output logic                             done_o,
  output logic                             passed_o,
  output logic                             timeout_o
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StBoot   = 3'd1,
    StTest   = 3'd2,
    StWfi    = 3'd3,
    StPassed = 3'd4,
    StFailed = 3'd5
  } chan_state_e;

  localparam int unsigned ToW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles + 1) : 1;

  chan_state_e            r_state      [NumChannels];
  chan_state_e            w_state_d    [NumChannels];
  chan_state_e            w_code_state [NumChannels];
  logic [NumChannels-1:0] w_hit;
  logic [NumChannels-1:0] w_code_ok;
  logic [NumChannels-1:0] w_chan_done;
  logic [NumChannels-1:0] w_chan_failed;
  logic [NumChannels-1:0] w_hb_expire;
  logic                   w_all_done;
  logic                   w_any_failed;
  logic                   w_term;
  logic                   w_to_hit;
  logic                   r_done;
  logic                   r_passed;
  logic                   r_timeout;
  logic [ToW-1:0]         r_to_cnt;

  // Address match and status-code decode per channel.
  always_comb begin
    for (int unsigned c = 0; c < NumChannels; c++) begin
      w_hit[c] = wr_valid_i[c] &&
                 (wr_addr_i[c*AddrWidth +: AddrWidth] == status_addr_i[c*AddrWidth +: AddrWidth]);
      w_code_state[c] = StIdle;
      w_code_ok[c]    = 1'b1;
      case (wr_data_i[c*16 +: 16])
        16'hb090: w_code_state[c] = StBoot;
        16'h4354: w_code_state[c] = StTest;
        16'h1d1e: w_code_state[c] = StWfi;
        16'h900d: w_code_state[c] = StPassed;
        16'hbaad: w_code_state[c] = StFailed;
        default:  w_code_ok[c]    = 1'b0;
      endcase
    end
  end

`ifdef SW_TEST_STATUS_HEARTBEAT_EN
  localparam int unsigned HbW = (HeartbeatCycles > 1) ? $clog2(HeartbeatCycles) : 1;

  logic [HbW-1:0] r_hb_cnt [NumChannels];

  always_comb begin
    for (int unsigned c = 0; c < NumChannels; c++) begin
      w_hb_expire[c] = (r_state[c] == StTest) && !w_hit[c] &&
                       (r_hb_cnt[c] == HbW'(HeartbeatCycles - 1));
    end
  end

  // Idle counter only runs while staying in Test; any decoded write or a state change clears it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned c = 0; c < NumChannels; c++) begin
        r_hb_cnt[c] <= '0;
      end
    end else if (!r_done) begin
      for (int unsigned c = 0; c < NumChannels; c++) begin
        if ((r_state[c] == StTest) && (w_state_d[c] == StTest) && !w_hit[c]) begin
          r_hb_cnt[c] <= r_hb_cnt[c] + 1'b1;
        end else begin
          r_hb_cnt[c] <= '0;
        end
      end
    end
  end
`else
  assign w_hb_expire = '0;
`endif

  always_comb begin
    for (int unsigned c = 0; c < NumChannels; c++) begin
      w_state_d[c] = r_state[c];
      if ((r_state[c] != StPassed) && (r_state[c] != StFailed)) begin
        if (w_hit[c] && w_code_ok[c]) begin
          w_state_d[c] = w_code_state[c];
        end else if (w_hb_expire[c]) begin
          w_state_d[c] = StFailed;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned c = 0; c < NumChannels; c++) begin
        r_state[c] <= StIdle;
      end
    end else if (!r_done) begin
      for (int unsigned c = 0; c < NumChannels; c++) begin
        r_state[c] <= w_state_d[c];
      end
    end
  end

  always_comb begin
    w_all_done   = 1'b1;
    w_any_failed = 1'b0;
    chan_state_o = '0;
    for (int unsigned c = 0; c < NumChannels; c++) begin
      w_chan_done[c]        = (r_state[c] == StPassed) || (r_state[c] == StFailed);
      w_chan_failed[c]      = (r_state[c] == StFailed);
      w_all_done            = w_all_done && w_chan_done[c];
      w_any_failed          = w_any_failed || w_chan_failed[c];
      chan_state_o[c*3 +: 3] = r_state[c];
    end
    w_term   = w_all_done || (FailFast && w_any_failed);
    w_to_hit = (TimeoutCycles != 0) && (r_to_cnt == ToW'(TimeoutCycles - 1));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_to_cnt <= '0;
    end else if (!r_done && (TimeoutCycles != 0) && (r_to_cnt != '1)) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  // Status-based termination has priority over a timeout landing in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_done    <= 1'b0;
      r_passed  <= 1'b0;
      r_timeout <= 1'b0;
    end else if (!r_done) begin
      if (w_term) begin
        r_done   <= 1'b1;
        r_passed <= !w_any_failed;
      end else if (w_to_hit) begin
        r_done    <= 1'b1;
        r_timeout <= 1'b1;
      end
    end
  end

  assign chan_done_o = w_chan_done;
  assign done_o      = r_done;
  assign passed_o    = r_passed;
  assign timeout_o   = r_timeout;

endmodule
